// File: rtl/binoc_pkg.sv
// Shared BiNoC definitions: flit field layout, flit types, port directions and
// the input-port FSM states.
package binoc_pkg;

    localparam int NUM_DIR  = 5;

    localparam int TYPE_MSB = 31;
    localparam int TYPE_LSB = 30;
    localparam int DSTX_MSB = 29;
    localparam int DSTX_LSB = 26;
    localparam int DSTY_MSB = 25;
    localparam int DSTY_LSB = 22;

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic [2:0] {
        DIR_LOCAL = 3'd0,
        DIR_NORTH = 3'd1,
        DIR_EAST  = 3'd2,
        DIR_SOUTH = 3'd3,
        DIR_WEST  = 3'd4
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUTE,
        ST_XFER
    } ip_state_e;

    function automatic logic isPacketStart(input flit_type_e t);
        return (t == FT_HEAD) || (t == FT_SINGLE);
    endfunction

    function automatic logic isPacketEnd(input flit_type_e t);
        return (t == FT_TAIL) || (t == FT_SINGLE);
    endfunction

endpackage

// File: rtl/binoc_input_port_if.sv
// Link bundles of the BiNoC input port: upstream flit handshake and the
// request/grant path toward the output ports.
interface binoc_link_if #(
    parameter int DATA_W = 32
);
    logic              reqUpStr;
    logic              gntUpStr;
    logic [DATA_W-1:0] PacketIn;
    logic              full;

    modport master (output reqUpStr, output PacketIn, input gntUpStr, input full);
    modport slave  (input reqUpStr, input PacketIn, output gntUpStr, output full);
endinterface

interface binoc_out_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_DIR = 5
);
    logic [NUM_DIR-1:0] reqOut;
    logic [NUM_DIR-1:0] gntOut;
    logic [DATA_W-1:0]  PacketOut;
    logic               validOut;

    modport master (output reqOut, output PacketOut, output validOut, input gntOut);
    modport slave  (input reqOut, input PacketOut, input validOut, output gntOut);
endinterface

// File: rtl/binoc_flit_fifo.sv
// Circular flit buffer with occupancy counter; head is read combinationally.
module binoc_flit_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wrPtr;
    logic [AW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rdPtr];

    // A full buffer refuses writes even when a pop frees a slot this cycle.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/binoc_input_port.sv
// BiNoC router input port: buffers upstream flits, XY-routes each packet from
// its head flit and streams it wormhole-style into one output direction.
module binoc_input_port
    import binoc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int COORD_W = 4,
    parameter int LOCAL_X = 1,
    parameter int LOCAL_Y = 1
) (
    input  logic        clk,
    input  logic        rst,
    binoc_link_if.slave i_up,
    binoc_out_if.master o_dn,
    output logic        o_err
);
    logic               w_full;
    logic               w_empty;
    logic               w_gnt;
    logic               w_pop;
    logic               w_valid;
    logic               w_setErr;
    logic [DATA_W-1:0]  w_head;
    flit_type_e         w_headType;
    logic [COORD_W-1:0] w_dstX;
    logic [COORD_W-1:0] w_dstY;
    dir_e               w_routeDir;
    dir_e               r_dir;
    ip_state_e          r_state;
    ip_state_e          w_nextState;
    logic [NUM_DIR-1:0] w_reqOut;
    logic               r_err;

    assign w_gnt         = i_up.reqUpStr & ~w_full;
    assign i_up.gntUpStr = w_gnt;
    assign i_up.full     = w_full;

    binoc_flit_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_gnt),
        .i_pop   (w_pop),
        .i_data  (i_up.PacketIn),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_headType = flit_type_e'(w_head[TYPE_MSB:TYPE_LSB]);
    assign w_dstX     = w_head[DSTX_MSB:DSTX_LSB];
    assign w_dstY     = w_head[DSTY_MSB:DSTY_LSB];

    // Dimension-order routing: resolve X completely before looking at Y.
    always_comb begin
        w_routeDir = DIR_LOCAL;
        if (w_dstX > COORD_W'(LOCAL_X)) begin
            w_routeDir = DIR_EAST;
        end else if (w_dstX < COORD_W'(LOCAL_X)) begin
            w_routeDir = DIR_WEST;
        end else if (w_dstY > COORD_W'(LOCAL_Y)) begin
            w_routeDir = DIR_NORTH;
        end else if (w_dstY < COORD_W'(LOCAL_Y)) begin
            w_routeDir = DIR_SOUTH;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        w_valid     = 1'b0;
        w_setErr    = 1'b0;
        w_reqOut    = '0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    if (isPacketStart(w_headType)) begin
                        w_nextState = ST_ROUTE;
                    end else begin
                        w_pop    = 1'b1;
                        w_setErr = 1'b1;
                    end
                end
            end
            ST_ROUTE: begin
                w_nextState = ST_XFER;
            end
            ST_XFER: begin
                // The request is held until the tail leaves, locking the output port.
                w_reqOut = NUM_DIR'(1) << r_dir;
                w_valid  = o_dn.gntOut[r_dir] & ~w_empty;
                w_pop    = w_valid;
                if (w_valid && isPacketEnd(w_headType)) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_dir   <= DIR_LOCAL;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == ST_ROUTE) begin
                r_dir <= w_routeDir;
            end
            if (w_setErr) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_dn.reqOut    = w_reqOut;
    assign o_dn.validOut  = w_valid;
    assign o_dn.PacketOut = w_head;
    assign o_err          = r_err;

endmodule

// File: tb/tb_binoc_input_port.sv
// Randomized and directed bench for binoc_input_port against a queue-based
// packet model of the input port.
module tb_binoc_input_port;
    import binoc_pkg::*;

    localparam int DEPTH = 8;
    localparam int LX    = 1;
    localparam int LY    = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err;

    always #5 clk = ~clk;

    binoc_link_if #(.DATA_W(32))              upIf ();
    binoc_out_if  #(.DATA_W(32), .NUM_DIR(5)) dnIf ();

    binoc_input_port #(
        .DATA_W  (32),
        .DEPTH   (DEPTH),
        .COORD_W (4),
        .LOCAL_X (LX),
        .LOCAL_Y (LY)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .i_up  (upIf.slave),
        .o_dn  (dnIf.master),
        .o_err (err)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Model: flits held in the buffer, packet phase (0 idle, 1 routing, 2 streaming).
    logic [31:0] mq [$];
    int          mPhase   = 0;
    int          mDir     = 0;
    bit          mErr     = 1'b0;
    bit          mAccepted = 1'b0;

    bit          eFull;
    bit          eGnt;
    bit          eValid;
    logic [4:0]  eReq;
    int          t;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int flitKind(input logic [31:0] f);
        return int'(f[31:30]);
    endfunction

    function automatic int routeOf(input logic [31:0] f);
        int dx = int'(f[29:26]);
        int dy = int'(f[25:22]);
        if (dx > LX) return 2;
        if (dx < LX) return 4;
        if (dy > LY) return 1;
        if (dy < LY) return 3;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            mPhase    = 0;
            mErr      = 1'b0;
            mAccepted = 1'b0;
            checkOutput("rst_reqOut", 32'(dnIf.reqOut), 32'd0);
            checkOutput("rst_validOut", 32'(dnIf.validOut), 32'd0);
            checkOutput("rst_full", 32'(upIf.full), 32'd0);
            checkOutput("rst_err", 32'(err), 32'd0);
            checkOutput("rst_gntUpStr", 32'(upIf.gntUpStr), 32'(upIf.reqUpStr));
        end else begin
            eFull  = (mq.size() == DEPTH);
            eGnt   = upIf.reqUpStr && !eFull;
            eReq   = (mPhase == 2) ? 5'(1 << mDir) : 5'd0;
            eValid = (mPhase == 2) && dnIf.gntOut[mDir] && (mq.size() > 0);
            checkOutput("gntUpStr", 32'(upIf.gntUpStr), 32'(eGnt));
            checkOutput("full", 32'(upIf.full), 32'(eFull));
            checkOutput("reqOut", 32'(dnIf.reqOut), 32'(eReq));
            checkOutput("validOut", 32'(dnIf.validOut), 32'(eValid));
            checkOutput("err", 32'(err), 32'(mErr));
            if (eValid) begin
                checkOutput("PacketOut", dnIf.PacketOut, mq[0]);
            end
            if (mPhase == 0 && mq.size() > 0) begin
                t = flitKind(mq[0]);
                if (t == 1 || t == 3) begin
                    mPhase = 1;
                end else begin
                    void'(mq.pop_front());
                    mErr = 1'b1;
                end
            end else if (mPhase == 1) begin
                mDir   = routeOf(mq[0]);
                mPhase = 2;
            end else if (eValid) begin
                t = flitKind(mq.pop_front());
                if (t == 2 || t == 3) begin
                    mPhase = 0;
                end
            end
            if (eGnt) begin
                mq.push_back(upIf.PacketIn);
            end
            mAccepted = eGnt;
        end
    end

    // One cycle of inputs; returns just after the falling edge of that cycle.
    task automatic applyStimulus(input bit req, input logic [31:0] data, input logic [4:0] gnt);
        @(posedge clk);
        #1;
        upIf.reqUpStr = req;
        upIf.PacketIn = data;
        dnIf.gntOut   = gnt;
        @(negedge clk);
        #1;
    endtask

    task automatic doReset(input bit checkAsync);
        @(posedge clk);
        #1;
        upIf.reqUpStr = 1'b0;
        upIf.PacketIn = '0;
        dnIf.gntOut   = '0;
        rst = 1'b1;
        #1;
        if (checkAsync) begin
            checkOutput("async_reqOut_drop", 32'(dnIf.reqOut), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("reset_PacketOut", dnIf.PacketOut, 32'd0);
            checkOutput("reset_gntUpStr", 32'(upIf.gntUpStr), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] mkFlit(input int kind, input int dx, input int dy);
        return {2'(kind), 4'(dx), 4'(dy), 22'($urandom)};
    endfunction

    logic [31:0] stream [$];
    logic [31:0] cap [$];
    logic [31:0] pkt3 [3];
    logic [4:0]  rg;
    int          cyc;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        upIf.reqUpStr = 1'b0;
        upIf.PacketIn = '0;
        dnIf.gntOut   = '0;
        pkt3[0] = 32'h4840_0000;
        pkt3[1] = 32'h0000_0055;
        pkt3[2] = 32'h8000_00AA;

        // Reset and gntUpStr following reqUpStr.
        doReset(1'b0);
        applyStimulus(1'b1, 32'hC440_0000, 5'h01);
        checkOutput("t1_gnt_follows_req", 32'(upIf.gntUpStr), 32'd1);
        repeat (6) applyStimulus(1'b0, '0, 5'h01);

        // Single flit to LOCAL.
        applyStimulus(1'b1, 32'hC440_0000, 5'h00);
        applyStimulus(1'b0, '0, 5'h00);
        checkOutput("t2_reqOut_early", 32'(dnIf.reqOut), 32'd0);
        applyStimulus(1'b0, '0, 5'h00);
        applyStimulus(1'b0, '0, 5'h01);
        checkOutput("t2_reqOut", 32'(dnIf.reqOut), 32'h01);
        checkOutput("t2_validOut", 32'(dnIf.validOut), 32'd1);
        checkOutput("t2_PacketOut", dnIf.PacketOut, 32'hC440_0000);
        applyStimulus(1'b0, '0, 5'h01);
        checkOutput("t2_validOut_once", 32'(dnIf.validOut), 32'd0);
        checkOutput("t2_reqOut_drop", 32'(dnIf.reqOut), 32'd0);

        // Three-flit packet to EAST with grant held.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, pkt3[i], 5'h04);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 5'h04);
            checkOutput("t3_reqOut", 32'(dnIf.reqOut), 32'h04);
            checkOutput("t3_validOut", 32'(dnIf.validOut), 32'd1);
            checkOutput("t3_PacketOut", dnIf.PacketOut, pkt3[i]);
        end
        applyStimulus(1'b0, '0, 5'h04);
        checkOutput("t3_reqOut_drop", 32'(dnIf.reqOut), 32'd0);

        // Same packet, grant toggling with unrelated grant bits always set.
        cap.delete();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, pkt3[i], 5'h1B);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, '0, (i % 2 == 1) ? 5'h1F : 5'h1B);
            if (dnIf.validOut) cap.push_back(dnIf.PacketOut);
        end
        checkOutput("t3_toggle_count", 32'(cap.size()), 32'd3);
        for (int i = 0; i < 3 && i < cap.size(); i++) begin
            checkOutput("t3_toggle_order", cap[i], pkt3[i]);
        end

        // Fill to full while NORTH is never granted.
        applyStimulus(1'b1, 32'h4480_0000, 5'h00);
        for (int i = 1; i < 8; i++) applyStimulus(1'b1, 32'(i), 5'h00);
        applyStimulus(1'b1, 32'h8000_00FF, 5'h00);
        checkOutput("t4_full", 32'(upIf.full), 32'd1);
        checkOutput("t4_gnt_blocked", 32'(upIf.gntUpStr), 32'd0);
        applyStimulus(1'b1, 32'h8000_00FF, 5'h02);
        checkOutput("t4_pop_while_full", 32'(dnIf.validOut), 32'd1);
        checkOutput("t4_no_write_on_pop", 32'(upIf.gntUpStr), 32'd0);
        applyStimulus(1'b1, 32'h8000_00FF, 5'h00);
        checkOutput("t4_full_fell", 32'(upIf.full), 32'd0);
        checkOutput("t4_write_accepted", 32'(upIf.gntUpStr), 32'd1);
        repeat (12) applyStimulus(1'b0, '0, 5'h02);
        checkOutput("t4_drained_reqOut", 32'(dnIf.reqOut), 32'd0);

        // Orphan body flit in idle.
        applyStimulus(1'b1, 32'h0000_0055, 5'h1F);
        repeat (3) applyStimulus(1'b0, '0, 5'h1F);
        checkOutput("t5_err", 32'(err), 32'd1);
        checkOutput("t5_no_req", 32'(dnIf.reqOut), 32'd0);

        // Reset in the middle of a WEST packet.
        applyStimulus(1'b1, 32'h4040_0000, 5'h00);
        applyStimulus(1'b1, 32'h0000_0077, 5'h00);
        applyStimulus(1'b0, '0, 5'h00);
        applyStimulus(1'b0, '0, 5'h10);
        checkOutput("t6_reqOut_west", 32'(dnIf.reqOut), 32'h10);
        checkOutput("t6_head_sent", dnIf.PacketOut, 32'h4040_0000);
        applyStimulus(1'b0, '0, 5'h00);
        doReset(1'b1);
        applyStimulus(1'b0, '0, 5'h1F);
        checkOutput("t6_fifo_empty", 32'(dnIf.validOut), 32'd0);
        checkOutput("t6_err_cleared", 32'(err), 32'd0);
        applyStimulus(1'b1, 32'hC440_0000, 5'h00);
        applyStimulus(1'b0, '0, 5'h00);
        applyStimulus(1'b0, '0, 5'h00);
        applyStimulus(1'b0, '0, 5'h01);
        checkOutput("t6_single_local", 32'(dnIf.reqOut), 32'h01);
        checkOutput("t6_single_data", dnIf.PacketOut, 32'hC440_0000);

        // Random traffic with mid-packet heads and occasional orphans.
        stream.delete();
        for (int p = 0; p < 150; p++) begin
            int len = $urandom_range(1, 4);
            int dx  = ($urandom % 10 == 0) ? 15 : $urandom_range(0, 3);
            int dy  = ($urandom % 10 == 0) ? 15 : $urandom_range(0, 3);
            if ($urandom % 8 == 0) stream.push_back(mkFlit(($urandom % 2 == 0) ? 0 : 2, dx, dy));
            if (len == 1) begin
                stream.push_back(mkFlit(3, dx, dy));
            end else begin
                stream.push_back(mkFlit(1, dx, dy));
                for (int b = 1; b < len - 1; b++) begin
                    stream.push_back(mkFlit(($urandom % 6 == 0) ? 1 : 0, $urandom_range(0, 15), $urandom_range(0, 15)));
                end
                stream.push_back(mkFlit(2, $urandom_range(0, 15), $urandom_range(0, 15)));
            end
        end
        cyc = 0;
        while (stream.size() > 0 && cyc < 4000) begin
            case ($urandom % 4)
                0:       rg = 5'h00;
                1:       rg = 5'h1F;
                default: rg = 5'($urandom);
            endcase
            applyStimulus(($urandom % 4) != 0, stream[0], rg);
            if (mAccepted) void'(stream.pop_front());
            cyc++;
        end
        if (stream.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL random_timeout: %0d flits left, required 0", stream.size());
        end
        repeat (20) applyStimulus(1'b0, '0, 5'h1F);
        checkOutput("final_reqOut", 32'(dnIf.reqOut), 32'd0);
        checkOutput("final_full", 32'(upIf.full), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
